// File: rtl/gray_position_tracker.sv
// Decodes a stream of 3-bit binary/Gray codes and tracks an up/down position from
// +/-1 steps modulo 8, flagging illegal jumps with a saturating error count.
module gray_position_tracker #(
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       code_in,
    input  logic             select,
    input  logic             clear,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             step_up,
    output logic             step_down,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic             sel_q, sel_d;
    logic [POS_W-1:0] position_q, position_d;
    logic             dir_q, dir_d;
    logic             step_up_q, step_up_d;
    logic             step_down_q, step_down_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [2:0] code_bin;
    logic [2:0] diff;

    always_comb begin
        code_bin[2] = code_in[2];
        code_bin[1] = code_in[2] ^ code_in[1];
        code_bin[0] = code_in[2] ^ code_in[1] ^ code_in[0];
        if (!select) code_bin = code_in;
    end

    // Wrap-around distance from the last decoded value; 1 is up, 7 is down.
    assign diff = code_bin - prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prev_q      <= 3'd0;
            sel_q       <= 1'b0;
            position_q  <= '0;
            dir_q       <= 1'b1;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            sel_q       <= sel_d;
            position_q  <= position_d;
            dir_q       <= dir_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (in_valid) begin
            state_d = ST_TRACK;
        end
    end

    always_comb begin
        prev_d      = prev_q;
        sel_d       = sel_q;
        position_d  = position_q;
        dir_d       = dir_q;
        err_count_d = err_count_q;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        err_pulse_d = 1'b0;
        if (clear) begin
            position_d  = '0;
            err_count_d = '0;
            dir_d       = 1'b1;
        end else if (in_valid) begin
            prev_d = code_bin;
            sel_d  = select;
            // A first sample or a mode change only re-references, never steps.
            if (state_q == ST_TRACK && select == sel_q) begin
                case (diff)
                    3'd0: ;
                    3'd1: begin
                        position_d = position_q + POS_W'(1);
                        step_up_d  = 1'b1;
                        dir_d      = 1'b1;
                    end
                    3'd7: begin
                        position_d  = position_q - POS_W'(1);
                        step_down_d = 1'b1;
                        dir_d       = 1'b0;
                    end
                    default: begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign position  = position_q;
    assign dir       = dir_q;
    assign step_up   = step_up_q;
    assign step_down = step_down_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign locked    = (state_q == ST_TRACK);

endmodule

// File: tb/tb_gray_position_tracker.sv
// Directed bench for gray_position_tracker with hand-computed expected outputs.
module tb_gray_position_tracker;

  localparam int POS_W = 8;
  localparam int ERR_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [2:0]       code_in;
  logic             select;
  logic             clear;
  logic [POS_W-1:0] position;
  logic             dir;
  logic             step_up;
  logic             step_down;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             locked;

  int n_checks = 0;
  int n_fail   = 0;

  gray_position_tracker #(.POS_W(POS_W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .code_in   (code_in),
    .select    (select),
    .clear     (clear),
    .position  (position),
    .dir       (dir),
    .step_up   (step_up),
    .step_down (step_down),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .locked    (locked)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int pos, input bit d, input bit up,
                            input bit dn, input bit er, input int ec, input bit lk);
    check({tag, ".position"},  32'(position),  32'(pos));
    check({tag, ".dir"},       32'(dir),       32'(d));
    check({tag, ".step_up"},   32'(step_up),   32'(up));
    check({tag, ".step_down"}, 32'(step_down), 32'(dn));
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'(er));
    check({tag, ".err_count"}, 32'(err_count), 32'(ec));
    check({tag, ".locked"},    32'(locked),    32'(lk));
  endtask

  // driver tasks: drive on the falling edge, sample 1ns after the rising edge
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; code_in = 3'd0; select = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input bit v, input logic [2:0] code, input bit sel, input bit clr);
    @(negedge clk);
    in_valid = v; code_in = code; select = sel; clear = clr;
    @(posedge clk); #1;
  endtask

  logic [2:0] gray_up [8];
  int ec_exp;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; code_in = 3'd0; select = 1'b0; clear = 1'b0;
    gray_up[0] = 3'b001; gray_up[1] = 3'b011; gray_up[2] = 3'b010; gray_up[3] = 3'b110;
    gray_up[4] = 3'b111; gray_up[5] = 3'b101; gray_up[6] = 3'b100; gray_up[7] = 3'b000;

    // reset values
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_outs("reset", 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // first Gray sample only references
    send(1, 3'b000, 1, 0);
    check_outs("first", 0, 1, 0, 0, 0, 0, 1);

    // Gray up-count through a full code cycle
    for (int i = 0; i < 8; i++) begin
      send(1, gray_up[i], 1, 0);
      check_outs($sformatf("gray_up%0d", i), i + 1, 1, 1, 0, 0, 0, 1);
    end
    send(1, 3'b000, 1, 0);
    check_outs("same_code", 8, 1, 0, 0, 0, 0, 1);
    send(0, 3'b011, 1, 0);
    check_outs("no_valid", 8, 1, 0, 0, 0, 0, 1);

    // binary reverse and position wrap both ways
    do_reset();
    send(1, 3'b000, 0, 0);
    check_outs("bin_ref", 0, 1, 0, 0, 0, 0, 1);
    send(1, 3'b111, 0, 0);
    check_outs("bin_0to7", 255, 0, 0, 1, 0, 0, 1);
    send(1, 3'b110, 0, 0);
    check_outs("bin_7to6", 254, 0, 0, 1, 0, 0, 1);
    send(1, 3'b111, 0, 0);
    check_outs("bin_6to7", 255, 1, 1, 0, 0, 0, 1);
    send(1, 3'b000, 0, 0);
    check_outs("bin_7to0", 0, 1, 1, 0, 0, 0, 1);

    // illegal jump, then a legal step from the new reference
    do_reset();
    send(1, 3'b000, 1, 0);
    check_outs("ill_ref", 0, 1, 0, 0, 0, 0, 1);
    send(1, 3'b011, 1, 0);
    check_outs("ill_jump", 0, 1, 0, 0, 1, 1, 1);
    send(1, 3'b010, 1, 0);
    check_outs("ill_after", 1, 1, 1, 0, 0, 1, 1);

    // 20 more illegal jumps alternating between binary 0 and 3
    ec_exp = 1;
    for (int k = 1; k <= 20; k++) begin
      send(1, (k % 2 == 1) ? 3'b000 : 3'b010, 1, 0);
      if (ec_exp < 15) ec_exp++;
      check_outs($sformatf("sat%0d", k), 1, 1, 0, 0, 1, ec_exp, 1);
    end
    send(1, 3'b110, 1, 0);
    check_outs("sat_up", 2, 1, 1, 0, 0, 15, 1);
    send(1, 3'b010, 1, 0);
    check_outs("sat_down", 1, 0, 0, 1, 0, 15, 1);

    // clear wins over a simultaneous sample
    send(1, 3'b011, 1, 1);
    check_outs("clear", 0, 1, 0, 0, 0, 0, 0);
    send(1, 3'b001, 1, 0);
    check_outs("clear_ref", 0, 1, 0, 0, 0, 0, 1);

    // mode switch re-references without a step
    do_reset();
    send(1, 3'b101, 0, 0);
    check_outs("mode_ref", 0, 1, 0, 0, 0, 0, 1);
    send(1, 3'b110, 0, 0);
    check_outs("mode_bin_up", 1, 1, 1, 0, 0, 0, 1);
    send(1, 3'b001, 1, 0);
    check_outs("mode_to_gray", 1, 1, 0, 0, 0, 0, 1);
    send(1, 3'b011, 1, 0);
    check_outs("mode_gray_up", 2, 1, 1, 0, 0, 0, 1);
    send(1, 3'b010, 0, 0);
    check_outs("mode_to_bin", 2, 1, 0, 0, 0, 0, 1);
    send(1, 3'b001, 0, 0);
    check_outs("mode_bin_down", 1, 0, 0, 1, 0, 0, 1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_position_tracker.md
# gray_position_tracker

Downstream consumer of the 3-bit Gray encoder stage. Accepts a stream of 3-bit codes, in either plain binary or reflected Gray form, as selected by the same `select` convention as the encoder. Decodes each code to binary and tracks a wide up/down position from ±1 steps modulo 8. Flags illegal jumps, keeping a saturating error count and step/direction indications for the control logic that follows.

## Interface
- `POS_W`, default 8: width of the position accumulator; wraps modulo 2^POS_W.
- `ERR_W`, default 4: width of the saturating error counter.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  `code_in` and `select` are sampled this cycle.
- `code_in`  input  3  incoming code word.
- `select`  input  1  0 = `code_in` is plain binary; 1 = `code_in` is reflected Gray.
- `clear`  input  1  synchronous clear of position, error count and lock.
- `position`  output  POS_W  accumulated position.
- `dir`  output  1  direction of last accepted step; 1 = up.
- `step_up`  output  1  one-cycle pulse: +1 step accepted.
- `step_down`  output  1  one-cycle pulse: −1 step accepted.
- `err_pulse`  output  1  one-cycle pulse: illegal jump detected.
- `err_count`  output  ERR_W  saturating count of illegal jumps.
- `locked`  output  1  a reference sample is held; the FSM is in TRACK.

## Operation
- **Decode:** if `select` = 1, then b[2] = g[2], b[1] = g[2]^g[1], b[0] = b[1]^g[0]. If `select` = 0, b = `code_in`.
- **Internal registers:**
  - `prev[2:0]`: last decoded value.
  - `sel_q`: `select` value of the last accepted sample.
- **FSM states:**
  - **IDLE:** no reference held; `locked` = 0.
  - **TRACK:** `locked` = 1.
- **IDLE, `in_valid` = 1:**
  - Load `prev` = b and `sel_q` = `select`.
  - Go to TRACK.
  - No step, no error.
- **TRACK, `in_valid` = 1 and `select` = `sel_q`:** compute d = (b − `prev`) mod 8, 3-bit wrap-around subtraction.
  - d = 0: no change, no pulses.
  - d = 1: `position` += 1 (wraps), `step_up` = 1, `dir` = 1.
  - d = 7: `position` −= 1 (wraps), `step_down` = 1, `dir` = 0.
  - d ∈ {2..6}: `err_pulse` = 1; `err_count` += 1, saturating at 2^ERR_W − 1; `position` and `dir` unchanged.
  - In every case, `prev` = b.
- **TRACK, `in_valid` = 1 and `select` ≠ `sel_q`:** mode switch.
  - Reload `prev` = b and `sel_q` = `select`.
  - Stay in TRACK with no step and no error (re-reference).
- **`in_valid` = 0:** hold all state; pulses are 0.
- **Priority, highest first:** `rst_n` = 0, then `clear`, then sample processing.
  - `clear` = 1: `position` = 0, `err_count` = 0, `dir` = 1, go to IDLE.
  - A sample presented in the same cycle as `clear` is discarded.

## Timing
- All outputs are registered. Latency is 1 cycle: a sample accepted at edge N shows its effect on outputs after edge N.
- Pulses (`step_up`, `step_down`, `err_pulse`) are high for exactly one cycle per accepted sample. At most one pulse is asserted per cycle.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.
- **Reset values** (applied at the edge where `rst_n` = 0):
  - `position` = 0, `dir` = 1, `err_count` = 0, `locked` = 0
  - `step_up` = 0, `step_down` = 0, `err_pulse` = 0
  - state = IDLE, `prev` = 0, `sel_q` = 0
- **Reset mid-stream:** the next valid sample after release is only a reference sample; no step is produced.
- **Wrap boundaries:**
  - `position` 2^POS_W − 1 with +1 gives 0; 0 with −1 gives 2^POS_W − 1.
  - Code wrap 7→0 counts as +1; 0→7 counts as −1.
- **Error counter at saturation:** `err_count` stays at maximum while `err_pulse` still fires.

## Test plan
- **Reset and first sample:** apply reset, then `select` = 1 and sample 000 → `locked` = 1 one cycle later; `position` = 0 and no pulses.
- **Gray up-count:** `select` = 1, codes 000,001,011,010,110,111,101,100,000 → `position` = 8, 8 `step_up` pulses, `dir` = 1.
- **Reverse and wrap:** `select` = 0, `POS_W` = 8. From reset, codes 000 then 111 → `step_down`, `position` = 255, `dir` = 0.
- **Illegal jump:** `select` = 1, codes 000 then 011 (binary 2) → `err_pulse`, `err_count` = 1, `position` unchanged. A following 010 (binary 3) → `step_up`.
- **Saturation and clear:** with `ERR_W` = 4, drive 20 illegal jumps → `err_count` = 15. Assert `clear` together with a valid sample → `err_count` = 0, `position` = 0, `locked` = 0, and the sample is ignored.
- **Mode switch:** in TRACK with `select` = 0, switch to `select` = 1 with code 001 → no pulse and `position` unchanged. Then 011 → `step_up`.
